// File: rtl/async_fifo_wr_arb.sv
// async_fifo_wr_arb: shares one async-FIFO write port among NREQ requesters.
// A winner gets an atomic burst of (len+1) words. Writes stall on fifo_full,
// and there is one idle cycle between bursts.
// Optional: define ASYNC_FIFO_ARB_FIXED_PRIO_EN for lowest-index-wins
// arbitration. The default build uses round robin.

// Per-requester slice: masks valid/data with this lane's grant bit.
module async_fifo_wr_arb_lane #(
  parameter int W = 8
) (
  input  logic         i_gnt,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);
  assign o_vld  = i_gnt & i_vld;
  assign o_data = i_data & {W{i_gnt}};
endmodule

module async_fifo_wr_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LW   = 4
) (
  input  logic                 wr_clk,
  input  logic                 wr_reset_n,
  input  logic [NREQ-1:0]      req_vld,
  input  logic [NREQ*W-1:0]    req_data,
  input  logic [NREQ*LW-1:0]   req_len,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      grant,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [W-1:0]         fifo_wr_data,
  output logic                 busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

  state_t                    r_state, w_state_nxt;
  logic [NREQ-1:0]           r_grant, w_grant_nxt;
  logic [LW-1:0]             r_beat_cnt, w_beat_nxt;
`ifndef ASYNC_FIFO_ARB_FIXED_PRIO_EN
  logic [PW-1:0]             r_last_ptr, w_last_nxt;
  logic [PW-1:0]             w_owner;
`endif
  logic [NREQ-1:0]           w_lane_vld;
  logic [NREQ-1:0][W-1:0]    w_lane_data;
  logic                      w_sel_vld;
  logic [W-1:0]              w_sel_data;
  logic                      w_wr;
  logic                      w_found;
  logic [PW-1:0]             w_win, w_idx;
  logic [LW-1:0]             w_len;

  // One masking slice per requester; the OR of the slices is the data mux.
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    async_fifo_wr_arb_lane #(.W(W)) u_lane (
      .i_gnt  (r_grant[g]),
      .i_vld  (req_vld[g]),
      .i_data (req_data[g*W +: W]),
      .o_vld  (w_lane_vld[g]),
      .o_data (w_lane_data[g])
    );
  end

  // OR-reduce the masked lanes; grant is one-hot or zero so this is a mux.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) w_sel_data = w_sel_data | w_lane_data[i];
    w_sel_vld = |w_lane_vld;
  end

  assign w_wr = (r_state == S_XFER) & w_sel_vld & ~fifo_full;

  // Winner select for the IDLE cycle.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
`ifdef ASYNC_FIFO_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PW'(k);
      if (!w_found && req_vld[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`else
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = PW'((int'(r_last_ptr) + k) % NREQ);
      if (!w_found && req_vld[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`endif
    w_len = req_len[w_win*LW +: LW];
  end

`ifndef ASYNC_FIFO_ARB_FIXED_PRIO_EN
  // Encode the current owner so it can become last_ptr at burst end.
  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NREQ; i++) if (r_grant[i]) w_owner = PW'(i);
  end
`endif

  // Next-state logic: grant in IDLE, count beats and release in XFER.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_beat_nxt  = r_beat_cnt;
`ifndef ASYNC_FIFO_ARB_FIXED_PRIO_EN
    w_last_nxt  = r_last_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_XFER;
          w_grant_nxt = NREQ'(1) << w_win;
          w_beat_nxt  = w_len;
        end
      end
      S_XFER: begin
        if (w_wr) begin
          if (r_beat_cnt == '0) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
`ifndef ASYNC_FIFO_ARB_FIXED_PRIO_EN
            w_last_nxt  = w_owner;
`endif
          end else begin
            w_beat_nxt = r_beat_cnt - LW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State register; reset drops any burst in flight.
  always_ff @(posedge wr_clk) begin
    if (!wr_reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_beat_cnt <= '0;
`ifndef ASYNC_FIFO_ARB_FIXED_PRIO_EN
      r_last_ptr <= PW'(NREQ - 1);
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_beat_cnt <= w_beat_nxt;
`ifndef ASYNC_FIFO_ARB_FIXED_PRIO_EN
      r_last_ptr <= w_last_nxt;
`endif
    end
  end

  assign fifo_wr_en   = w_wr;
  assign fifo_wr_data = w_sel_data;
  assign req_ack      = r_grant & {NREQ{w_wr}};
  assign grant        = r_grant;
  assign busy         = (r_state == S_XFER);
endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Bench for async_fifo_wr_arb: vector table, directed corner sequences and
// random traffic checked against a burst-level reference model.
module tb_async_fifo_wr_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LW   = 4;

  logic                wr_clk = 1'b0;
  logic                wr_reset_n;
  logic [NREQ-1:0]     req_vld;
  logic [NREQ*W-1:0]   req_data;
  logic [NREQ*LW-1:0]  req_len;
  logic [NREQ-1:0]     req_ack;
  logic [NREQ-1:0]     grant;
  logic                fifo_full;
  logic                fifo_wr_en;
  logic [W-1:0]        fifo_wr_data;
  logic                busy;

  int checks = 0;
  int errors = 0;

  async_fifo_wr_arb #(.NREQ(NREQ), .W(W), .LW(LW)) dut (
    .wr_clk       (wr_clk),
    .wr_reset_n   (wr_reset_n),
    .req_vld      (req_vld),
    .req_data     (req_data),
    .req_len      (req_len),
    .req_ack      (req_ack),
    .grant        (grant),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy)
  );

  always #5 wr_clk = ~wr_clk;

  // Reference model: owner index (-1 idle), words left, last winner.
  int m_owner = -1;
  int m_rem   = 0;
  int m_last  = NREQ - 1;

  function automatic int pick(logic [NREQ-1:0] v, int last);
`ifdef ASYNC_FIFO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare all outputs with the model for the current cycle.
  task automatic model_check();
    logic [NREQ-1:0] eg, ea;
    logic            ew, eb;
    logic [W-1:0]    ed;
    eg = '0; ew = 1'b0; ed = '0; eb = 1'b0;
    if (m_owner >= 0) begin
      eg = NREQ'(1) << m_owner;
      ew = req_vld[m_owner] && !fifo_full;
      ed = req_data[m_owner*W +: W];
      eb = 1'b1;
    end
    ea = ew ? eg : '0;
    chk("model", {13'd0, grant, req_ack, fifo_wr_en, fifo_wr_data, busy},
                 {13'd0, eg, ea, ew, ed, eb});
  endtask

  task automatic model_update();
    int p;
    if (!wr_reset_n) begin
      m_owner = -1; m_rem = 0; m_last = NREQ - 1;
    end else if (m_owner < 0) begin
      p = pick(req_vld, m_last);
      if (p >= 0) begin
        m_owner = p;
        m_rem   = int'(req_len[p*LW +: LW]) + 1;
      end
    end else if (req_vld[m_owner] && !fifo_full) begin
      m_rem--;
      if (m_rem == 0) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  // Call at the negedge: model compare, then advance across the posedge.
  task automatic tick();
    model_check();
    @(posedge wr_clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    @(negedge wr_clk);
    tick();
  endtask

  task automatic set_in(input logic rst, input logic [NREQ-1:0] v, input logic [LW-1:0] len,
                        input logic [W-1:0] d, input logic full);
    wr_reset_n = rst;
    req_vld    = v;
    req_len    = {NREQ{len}};
    req_data   = {NREQ{d}};
    fifo_full  = full;
  endtask

  task automatic do_reset();
    set_in(1'b0, '0, '0, '0, 1'b0);
    cycle();
    wr_reset_n = 1'b1;
  endtask

  typedef struct {
    logic            rst_n;
    logic [NREQ-1:0] vld;
    logic            full;
    logic [LW-1:0]   len;
    logic [W-1:0]    data;
    logic [NREQ-1:0] eg;
    logic            ew;
    logic [NREQ-1:0] ea;
    logic [W-1:0]    ed;
    logic            eb;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] v, logic f, logic [3:0] l, logic [7:0] d,
                              logic [3:0] eg, logic ew, logic [3:0] ea, logic [7:0] ed, logic eb);
    vec_t x;
    x.rst_n = r; x.vld = v; x.full = f; x.len = l; x.data = d;
    x.eg = eg; x.ew = ew; x.ea = ea; x.ed = ed; x.eb = eb;
    return x;
  endfunction

  vec_t vt[$];
  int   order[$];
  int   exp_order[5];
  int   nwr;
  logic [NREQ-1:0] t4_vld [9];
  logic [NREQ-1:0] t4_g   [9];
  logic            t4_w   [9];

  initial begin
    // Single burst on requester 2, then a full-stall burst on requester 1.
    vt.push_back(mk(0, 4'b0000, 0, 0, 8'h00, 4'b0000, 0, 4'b0000, 8'h00, 0));
    vt.push_back(mk(1, 4'b0100, 0, 3, 8'hA0, 4'b0000, 0, 4'b0000, 8'h00, 0));
    vt.push_back(mk(1, 4'b0100, 0, 3, 8'hA0, 4'b0100, 1, 4'b0100, 8'hA0, 1));
    vt.push_back(mk(1, 4'b0100, 0, 3, 8'hA1, 4'b0100, 1, 4'b0100, 8'hA1, 1));
    vt.push_back(mk(1, 4'b0100, 0, 3, 8'hA2, 4'b0100, 1, 4'b0100, 8'hA2, 1));
    vt.push_back(mk(1, 4'b0100, 0, 3, 8'hA3, 4'b0100, 1, 4'b0100, 8'hA3, 1));
    vt.push_back(mk(1, 4'b0000, 0, 3, 8'hA3, 4'b0000, 0, 4'b0000, 8'h00, 0));
    vt.push_back(mk(1, 4'b0010, 0, 2, 8'hB0, 4'b0000, 0, 4'b0000, 8'h00, 0));
    vt.push_back(mk(1, 4'b0010, 0, 2, 8'hB0, 4'b0010, 1, 4'b0010, 8'hB0, 1));
    vt.push_back(mk(1, 4'b0010, 1, 2, 8'hB1, 4'b0010, 0, 4'b0000, 8'hB1, 1));
    vt.push_back(mk(1, 4'b0010, 1, 2, 8'hB1, 4'b0010, 0, 4'b0000, 8'hB1, 1));
    vt.push_back(mk(1, 4'b0010, 1, 2, 8'hB1, 4'b0010, 0, 4'b0000, 8'hB1, 1));
    vt.push_back(mk(1, 4'b0010, 0, 2, 8'hB1, 4'b0010, 1, 4'b0010, 8'hB1, 1));
    vt.push_back(mk(1, 4'b0010, 0, 2, 8'hB2, 4'b0010, 1, 4'b0010, 8'hB2, 1));
    vt.push_back(mk(1, 4'b0000, 0, 2, 8'hB2, 4'b0000, 0, 4'b0000, 8'h00, 0));

    set_in(1'b0, '0, '0, '0, 1'b0);
    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].rst_n, vt[i].vld, vt[i].len, vt[i].data, vt[i].full);
      @(negedge wr_clk);
      chk($sformatf("vec%0d", i), {13'd0, grant, req_ack, fifo_wr_en, fifo_wr_data, busy},
          {13'd0, vt[i].eg, vt[i].ea, vt[i].ew, vt[i].ed, vt[i].eb});
      tick();
    end

    // Round robin with single-word bursts: one write every 2 cycles.
    do_reset();
    set_in(1'b1, 4'b1111, 4'd0, 8'h5C, 1'b0);
    order.delete();
    for (int c = 0; c < 10; c++) begin
      @(negedge wr_clk);
      if (fifo_wr_en)
        for (int i = 0; i < NREQ; i++) if (grant[i]) order.push_back(i);
      tick();
    end
`ifdef ASYNC_FIFO_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    chk("rr_writes", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);

    // Requester gap: req0 drops valid mid-burst, req1 waits its turn.
    do_reset();
    t4_vld = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0010, 4'b0010};
    t4_g   = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    t4_w   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 9; c++) begin
      set_in(1'b1, t4_vld[c], 4'd3, 8'(8'h40 + c), 1'b0);
      @(negedge wr_clk);
      chk($sformatf("gap_grant%0d", c), 32'(grant), 32'(t4_g[c]));
      chk($sformatf("gap_wen%0d", c), 32'(fifo_wr_en), 32'(t4_w[c]));
      tick();
    end

    // Reset after 2 of 8 words.
    do_reset();
    nwr = 0;
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 4'b0001, 4'd7, 8'(8'h60 + c), 1'b0);
      @(negedge wr_clk);
      if (fifo_wr_en) nwr++;
      tick();
    end
    chk("rst_pre_writes", nwr, 2);
    set_in(1'b0, 4'b0000, 4'd7, 8'h63, 1'b0);
    cycle();
    set_in(1'b1, 4'b1111, 4'd7, 8'h64, 1'b0);
    @(negedge wr_clk);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wen", 32'(fifo_wr_en), 0);
    tick();
    @(negedge wr_clk);
    chk("rst_first", 32'(grant), 32'(4'b0001));
    tick();

    // Maximum burst length: 16 writes, then IDLE.
    do_reset();
    nwr = 0;
    for (int c = 0; c < 20; c++) begin
      set_in(1'b1, (c < 17) ? 4'b1000 : 4'b0000, 4'hF, 8'(c), 1'b0);
      @(negedge wr_clk);
      if (fifo_wr_en) nwr++;
      if (c == 16) chk("max_last_busy", 32'(busy), 1);
      if (c == 17) chk("max_idle_grant", 32'(grant), 0);
      tick();
    end
    chk("max_writes", nwr, 16);
    chk("max_busy_end", 32'(busy), 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wr_reset_n = ($urandom_range(0, 299) != 0);
      req_vld    = NREQ'($urandom) | NREQ'($urandom);
      fifo_full  = ($urandom_range(0, 3) == 0);
      req_data   = $urandom;
      for (int i = 0; i < NREQ; i++)
        req_len[i*LW +: LW] = ($urandom_range(0, 9) == 0) ? 4'hF : LW'($urandom_range(0, 3));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
